iterative_shifter: RTL and testbench
====================================

Name: iterative_shifter

Overview:
- Multi-cycle, parametrised shifter/rotator.
- Generalises the fixed-width, fixed-amount left-shift-by-2 used in jump-target formation to any width, any runtime shift amount, and four modes: SLL, SRL, SRA, ROL.
- Shifts up to STEP bit positions per cycle under a start/busy/done handshake.
- Sits beside the ALU as the shift-instruction execution unit; the pipeline stalls while busy.

Parameters:
- WIDTH, 32, data width in bits; must be a power of 2, at least 2.
- STEP, 4, maximum bit positions shifted per cycle; 1 <= STEP <= WIDTH.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL; latched on accepted start
- din  input  WIDTH  operand; latched on accepted start
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; latched on accepted start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; dout valid
- dout  output  WIDTH  result register; holds last result

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, dout=0, internal accumulator and remaining count = 0.
- Reset mid-operation (SHIFT or DONE):
  - Abort at the next edge and clear to reset values.
  - No done pulse for the aborted operation.
- States:
  - IDLE:
    - If start=1: latch din→acc, shamt→rem, mode→mode_r; go SHIFT.
    - Otherwise stay.
  - SHIFT: each edge, k = min(rem, STEP).
    - acc ← step(acc, k, mode_r); rem ← rem − k.
    - If rem <= STEP: dout ← shifted value; go DONE.
  - DONE: done=1 for exactly this cycle; go IDLE at next edge.
- Latency:
  - Shifting cycles = max(1, ceil(shamt/STEP)).
  - done is high in the cycle after the last shifting edge.
  - shamt=0 takes one SHIFT cycle and returns din unchanged.
- start while busy=1 is ignored; no queuing.
- start in the same cycle DONE exits is ignored; it is re-sampled in IDLE.
- Step arithmetic:
  - SLL: zero fill at the LSBs.
  - SRL: zero fill at the MSBs.
  - SRA: fill with acc[WIDTH-1] at every step, which preserves the original sign.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Results are exact modulo 2^WIDTH; there is no overflow flag.
- dout changes only on entry to DONE or on reset.
- Inputs are not sampled outside accepted starts.

Decomposition:
- Shared package shifter_pkg:
  - mode encodings MODE_SLL/SRL/SRA/ROL;
  - state encoding IDLE/SHIFT/DONE.
- Natural sub-module: shift_step.
  - Combinational.
  - Shifts a WIDTH-bit value by k (0..STEP) in the given mode.
  - Instantiated once in the SHIFT datapath.

Test Plan (WIDTH=32, STEP=4):
1. SLL, din=0x00000001, shamt=2 → one SHIFT cycle; done the following cycle; dout=0x00000004, matching the legacy <<2.
2. SRA, din=0x80000000, shamt=31 → eight SHIFT cycles; busy high 9 cycles; dout=0xFFFFFFFF.
3. SRL, din=0x80000000, shamt=31 → dout=0x00000001; then SRL, din=0xF0000000, shamt=4 → dout=0x0F000000 after one cycle.
4. ROL, din=0x80000001, shamt=5 → two SHIFT cycles; dout=0x00000030.
5. SLL, din=0xDEADBEEF, shamt=0 → done after one SHIFT cycle; dout=0xDEADBEEF. A second start pulse asserted while busy produces no extra done and does not change dout.
6. SLL, shamt=20, reset asserted in the third SHIFT cycle → next edge busy=0, done=0, dout=0, no done pulse. A following start with din=0x1, shamt=1 → dout=0x2.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter.
// Holds mode and FSM state enums used by the top and the step unit.
package shifter_pkg;

   typedef enum logic [1:0] {
      MODE_SLL = 2'b00,
      MODE_SRL = 2'b01,
      MODE_SRA = 2'b10,
      MODE_ROL = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts din by k (0..STEP) in mode.
// Ports: din/k/mode in, dout out.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] din,
   input  logic [KW-1:0]    k,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] dout
);

   // Wide enough to hold WIDTH itself, so k=0 gives a full-width
   // right shift (all zeros) on the rotate wrap path.
   localparam int SW = $clog2(WIDTH) + 1;

   logic [SW-1:0]    wrap_amt;
   logic [WIDTH-1:0] rol_val;

   always_comb begin
      wrap_amt = SW'(WIDTH) - SW'(k);
      rol_val  = (din << k) | (din >> wrap_amt);
   end

   always_comb begin
      dout = din;
      unique case (mode)
         MODE_SLL: dout = din << k;
         MODE_SRL: dout = din >> k;
         MODE_SRA: dout = $signed(din) >>> k;
         MODE_ROL: dout = rol_val;
         default:  dout = din;
      endcase
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: up to STEP bit positions per cycle.
// Ports: clk, reset, start/mode/din/shamt in; busy, done, dout out.
module iterative_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int STEP     = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   localparam int KW = $clog2(STEP + 1);
   // STEP can equal WIDTH, so remaining-count math uses one extra bit.
   localparam logic [SHAMT_W:0] STEP_X = (SHAMT_W + 1)'(STEP);

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0]   dout_q, dout_d;

   logic [SHAMT_W:0]   rem_x;
   logic [SHAMT_W:0]   rem_left;
   logic [KW-1:0]      k;
   logic               last;
   logic [WIDTH-1:0]   step_out;

   always_comb begin
      rem_x    = {1'b0, rem_q};
      last     = (rem_x <= STEP_X);
      k        = last ? rem_x[KW-1:0] : KW'(STEP);
      rem_left = rem_x - (SHAMT_W + 1)'(k);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .din  (acc_q),
      .k    (k),
      .mode (mode_q),
      .dout (step_out)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      dout_d  = dout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = din;
               rem_d   = shamt;
               mode_d  = mode_e'(mode);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = step_out;
            rem_d = rem_left[SHAMT_W-1:0];
            if (last) begin
               dout_d  = step_out;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= MODE_SLL;
         acc_q   <= '0;
         rem_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         dout_q  <= dout_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign dout = dout_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed scoreboard bench for iterative_shifter (WIDTH=32, STEP=4).
// Bit-serial reference model; results queued at start, checked on done.
module tb_iterative_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode_i;
   logic [31:0] din_i;
   logic [4:0]  shamt_i;
   logic        busy;
   logic        done;
   logic [31:0] dout;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   iterative_shifter #(
      .WIDTH (32),
      .STEP  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode_i),
      .din   (din_i),
      .shamt (shamt_i),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   function automatic logic [31:0] model(input logic [1:0] m,
                                         input logic [31:0] d,
                                         input int s);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < s; i++) begin
         case (m)
            2'b00:   r = {r[30:0], 1'b0};
            2'b01:   r = {1'b0, r[31:1]};
            2'b10:   r = {r[31], r[31:1]};
            default: r = {r[30:0], r[31]};
         endcase
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] m,
                        input logic [31:0] d, input logic [4:0] s,
                        input int exp_cyc, input bit poke);
      int cyc;
      int bcyc;
      logic [31:0] exp;
      @(negedge clk);
      mode_i  = m;
      din_i   = d;
      shamt_i = s;
      start   = 1'b1;
      sb.push_back(model(m, d, int'(s)));
      @(negedge clk);
      start = poke;
      if (poke) begin
         mode_i  = 2'b11;
         din_i   = 32'hFFFF_0000;
         shamt_i = 5'd7;
      end else begin
         din_i = $urandom;
      end
      cyc  = 0;
      bcyc = 0;
      while (!done && cyc < 64) begin
         if (busy) bcyc++;
         cyc++;
         @(negedge clk);
      end
      if (busy) bcyc++;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_busy_cycles"}, bcyc, exp_cyc + 1);
      exp = sb.pop_front();
      check({tag, "_dout"}, dout, exp);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check({tag, "_no_extra_done"}, 32'(done), 32'd0);
         check({tag, "_dout_hold"}, dout, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      mode_i  = 2'b00;
      din_i   = '0;
      shamt_i = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dout", dout, 32'd0);
      reset = 1'b0;

      do_op("t1_sll", 2'b00, 32'h0000_0001, 5'd2, 1, 1'b0);
      check("t1_legacy", dout, 32'h0000_0004);
      do_op("t2_sra", 2'b10, 32'h8000_0000, 5'd31, 8, 1'b0);
      check("t2_val", dout, 32'hFFFF_FFFF);
      do_op("t3_srl", 2'b01, 32'h8000_0000, 5'd31, 8, 1'b0);
      check("t3_val", dout, 32'h0000_0001);
      do_op("t3b_srl", 2'b01, 32'hF000_0000, 5'd4, 1, 1'b0);
      check("t3b_val", dout, 32'h0F00_0000);
      do_op("t4_rol", 2'b11, 32'h8000_0001, 5'd5, 2, 1'b0);
      check("t4_val", dout, 32'h0000_0030);
      do_op("t5_sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 1, 1'b1);
      check("t5_val", dout, 32'hDEAD_BEEF);
      do_op("tx_sra8", 2'b10, 32'h7F00_0000, 5'd8, 2, 1'b0);

      // Reset in the third SHIFT cycle of a 5-cycle operation.
      @(negedge clk);
      mode_i  = 2'b00;
      din_i   = 32'h0000_0003;
      shamt_i = 5'd20;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t6_shift1", 32'(busy), 32'd1);
      @(negedge clk);
      check("t6_shift2", 32'(busy), 32'd1);
      @(negedge clk);
      check("t6_shift3", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_abort_busy", 32'(busy), 32'd0);
      check("t6_abort_done", 32'(done), 32'd0);
      check("t6_abort_dout", dout, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_done", 32'(done), 32'd0);
      end
      do_op("t6_after", 2'b00, 32'h0000_0001, 5'd1, 1, 1'b0);
      check("t6_val", dout, 32'h0000_0002);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
